load_store_unit: RTL and testbench

- Memory-side initiator for the processor's data memory.
- Accepts one load or store request at a time from the execute stage over a valid/ready handshake.
- Converts the byte address to a 10-bit word index, checks alignment and range, and drives memRead/memWrite/address/data_in to data_memory.
- Returns load data with a resp_valid pulse and stalls the pipeline through `busy`.

---
 rtl/load_store_unit.sv | 112 +++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for data_memory: one request at a time, word-indexed
// access with alignment and range checking, registered memory controls.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | ready for a request; memRead/memWrite low
//   WRITE   | memWrite high for this single cycle; memory writes at its end
//   RD_WAIT | memRead held; latency timer counts down to terminal count 1
//   RESP    | resp_valid pulse (resp_err qualifies it); back to IDLE next
module load_store_unit #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  // 2 bits cover the legal read latency range of 1..3
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY);

  logic [1:0]        state;
  logic [1:0]        lat_cnt;
  logic              err_q;
  logic              accept;
  logic              addr_err;
  logic [ADDR_W-1:0] word_idx;

  assign accept   = req_valid && req_ready;
  assign word_idx = req_addr[ADDR_W+1:2];
  // misaligned byte address, or any byte address beyond the last word
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);

  assign req_ready  = (state == S_IDLE);
  assign busy       = (req_valid && !req_ready) || (state != S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_err   = (state == S_RESP) && err_q;

  // Request sequencing; address/data_in/resp_rdata hold their last values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_cnt    <= 2'd0;
      err_q      <= 1'b0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      address    <= '0;
      data_in    <= 32'd0;
      resp_rdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (addr_err) begin
              err_q <= 1'b1;
              state <= S_RESP;
            end else if (req_write) begin
              err_q    <= 1'b0;
              address  <= word_idx;
              data_in  <= req_wdata;
              memWrite <= 1'b1;
              state    <= S_WRITE;
            end else begin
              err_q   <= 1'b0;
              address <= word_idx;
              memRead <= 1'b1;
              lat_cnt <= LAT_LOAD;
              state   <= S_RD_WAIT;
            end
          end
        end
        S_WRITE: begin
          memWrite <= 1'b0;
          state    <= S_RESP;
        end
        S_RD_WAIT: begin
          if (lat_cnt == 2'd1) begin
            resp_rdata <= data_out;
            memRead    <= 1'b0;
            lat_cnt    <= 2'd0;
            state      <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table on a READ_LATENCY=1 instance with a
// behavioural memory, plus hand sequences for back-to-back requests and for
// reset during a READ_LATENCY=3 load.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, reset3;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy, memRead, memWrite;
  logic [31:0] resp_rdata, data_in, data_out;
  logic [9:0]  address;

  logic        req_valid3, req_write3;
  logic [31:0] req_addr3, req_wdata3;
  logic        req_ready3, resp_valid3, resp_err3, busy3, memRead3, memWrite3;
  logic [31:0] resp_rdata3, data_in3, data_out3;
  logic [9:0]  address3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(10), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .memRead(memRead), .memWrite(memWrite), .address(address),
    .data_in(data_in), .data_out(data_out)
  );

  load_store_unit #(.ADDR_W(10), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_write(req_write3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .req_ready(req_ready3),
    .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .busy(busy3), .memRead(memRead3), .memWrite(memWrite3), .address(address3),
    .data_in(data_in3), .data_out(data_out3)
  );

  // Memory for the latency-1 instance: synchronous write, read data valid
  // while memRead is high, poison value otherwise.
  logic [31:0] mem [0:1023];
  always @(posedge clk) if (memWrite) mem[address] <= data_in;
  assign data_out = memRead ? mem[address] : 32'hBAD0BAD0;

  // Latency-3 memory: data (an address-derived pattern) only becomes valid
  // after memRead has been sampled high on two edges.
  int rd_cnt3 = 0;
  always @(posedge clk) rd_cnt3 <= memRead3 ? rd_cnt3 + 1 : 0;
  assign data_out3 = (memRead3 && rd_cnt3 >= 2) ? (32'hA5A50000 ^ {22'd0, address3})
                                                : 32'hBAD0BAD0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [9:0]  maddr;
    logic [31:0] mdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[10];

  // Issue one request on dut and observe it until resp_valid (bounded).
  task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int nrd, output int nwr,
                         output logic [9:0] maddr, output logic [31:0] mdata,
                         output logic got, output logic err, output logic both);
    lat = 0; nrd = 0; nwr = 0; maddr = '0; mdata = '0; got = 0; err = 0; both = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_addr = 32'h0000_0040; req_wdata = 32'h5555_AAAA;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (memRead)  begin nrd++; maddr = address; end
      if (memWrite) begin nwr++; maddr = address; mdata = data_in; end
      if (memRead && memWrite) both = 1;
      if (resp_valid) begin
        lat = k; got = 1; err = resp_err;
        break;
      end
    end
  endtask

  initial begin
    int lat, nrd, nwr;
    logic [9:0] maddr;
    logic [31:0] mdata;
    logic got, err, both;
    logic [4:0] exp_ready, exp_busy, exp_rv, exp_rd, exp_wr;
    int rv_cnt;

    //            w     addr          wdata         err   lat nrd nwr maddr     mdata          rdata
    vecs[0] = '{1'b1, 32'h24,       32'd748,       1'b0, 2, 0, 1, 10'd9,    32'd748,       32'd0};
    vecs[1] = '{1'b0, 32'h24,       32'd543,       1'b0, 2, 1, 0, 10'd9,    32'd0,         32'd748};
    vecs[2] = '{1'b1, 32'h0,        32'd2,         1'b0, 2, 0, 1, 10'd0,    32'd2,         32'd748};
    vecs[3] = '{1'b0, 32'h0,        32'd0,         1'b0, 2, 1, 0, 10'd0,    32'd0,         32'd2};
    vecs[4] = '{1'b0, 32'h26,       32'd0,         1'b1, 1, 0, 0, 10'd0,    32'd0,         32'd2};
    vecs[5] = '{1'b1, 32'h1000,     32'd5,         1'b1, 1, 0, 0, 10'd0,    32'd0,         32'd2};
    vecs[6] = '{1'b1, 32'hFFC,      32'hDEADBEEF,  1'b0, 2, 0, 1, 10'd1023, 32'hDEADBEEF,  32'd2};
    vecs[7] = '{1'b0, 32'hFFC,      32'd0,         1'b0, 2, 1, 0, 10'd1023, 32'd0,         32'hDEADBEEF};
    vecs[8] = '{1'b0, 32'h0,        32'd0,         1'b0, 2, 1, 0, 10'd0,    32'd0,         32'd2};
    vecs[9] = '{1'b1, 32'h8000_0010, 32'd9,        1'b1, 1, 0, 0, 10'd0,    32'd0,         32'd2};

    reset = 1'b1; reset3 = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    req_valid3 = 0; req_write3 = 0; req_addr3 = 0; req_wdata3 = 0;
    #10;
    reset = 1'b0; reset3 = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_memrd_memwr", {30'd0, memRead, memWrite}, 32'd0);
    chk("rst_address", {22'd0, address}, 32'd0);
    chk("rst_data_in", data_in, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].w, vecs[i].addr, vecs[i].wdata, lat, nrd, nwr, maddr, mdata, got, err, both);
      chk($sformatf("v%0d_resp_seen", i), {31'd0, got}, 32'd1);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_memRead_cycles", i), nrd, vecs[i].nrd);
      chk($sformatf("v%0d_memWrite_cycles", i), nwr, vecs[i].nwr);
      chk($sformatf("v%0d_rd_wr_overlap", i), {31'd0, both}, 32'd0);
      if (vecs[i].nrd + vecs[i].nwr > 0)
        chk($sformatf("v%0d_address", i), {22'd0, maddr}, {22'd0, vecs[i].maddr});
      if (vecs[i].nwr > 0)
        chk($sformatf("v%0d_data_in", i), mdata, vecs[i].mdata);
      chk($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].rdata);
    end

    // Back-to-back: store 2 to 0x8, then a load of 0x8 held valid while busy.
    // Request fields change during the store and must be ignored.
    exp_ready = 5'b00100;  // bit k-1 = cycle k after first acceptance
    exp_busy  = 5'b11011;
    exp_rv    = 5'b10010;
    exp_rd    = 5'b01000;
    exp_wr    = 5'b00001;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'd2;
    @(posedge clk);
    #1;
    req_write = 1'b0; req_wdata = 32'd543;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_c%0d_ready", k), {31'd0, req_ready}, {31'd0, exp_ready[k-1]});
      chk($sformatf("b2b_c%0d_busy", k), {31'd0, busy}, {31'd0, exp_busy[k-1]});
      chk($sformatf("b2b_c%0d_resp_valid", k), {31'd0, resp_valid}, {31'd0, exp_rv[k-1]});
      chk($sformatf("b2b_c%0d_memRead", k), {31'd0, memRead}, {31'd0, exp_rd[k-1]});
      chk($sformatf("b2b_c%0d_memWrite", k), {31'd0, memWrite}, {31'd0, exp_wr[k-1]});
      if (k == 1) begin
        chk("b2b_wr_address", {22'd0, address}, 32'd2);
        chk("b2b_wr_data_in", data_in, 32'd2);
      end
      if (k == 4) req_valid = 1'b0;
    end
    chk("b2b_rdata", resp_rdata, 32'd2);

    // READ_LATENCY=3 load of 0x24: word 9, pattern A5A50009
    @(negedge clk);
    req_valid3 = 1'b1; req_write3 = 1'b0; req_addr3 = 32'h24;
    @(posedge clk);
    #1;
    req_valid3 = 1'b0;
    lat = 0; nrd = 0; nwr = 0; err = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (memRead3) nrd++;
      if (memWrite3) nwr++;
      if (resp_valid3) begin lat = k; err = resp_err3; break; end
    end
    chk("rl3_latency", lat, 4);
    chk("rl3_memRead_cycles", nrd, 3);
    chk("rl3_memWrite_cycles", nwr, 0);
    chk("rl3_err", {31'd0, err}, 32'd0);
    chk("rl3_address", {22'd0, address3}, 32'd9);
    chk("rl3_rdata", resp_rdata3, 32'hA5A50009);
    chk("rl3_data_in", data_in3, 32'd0);

    // Reset in the middle of a READ_LATENCY=3 load
    @(negedge clk);
    req_valid3 = 1'b1; req_write3 = 1'b0; req_addr3 = 32'h30;
    @(posedge clk);
    #1;
    req_valid3 = 1'b0;
    @(negedge clk);
    chk("mid_c1_memRead", {31'd0, memRead3}, 32'd1);
    @(negedge clk);
    chk("mid_c2_memRead", {31'd0, memRead3}, 32'd1);
    chk("mid_c2_busy", {31'd0, busy3}, 32'd1);
    #1;
    reset3 = 1'b1;
    #1;
    chk("mid_async_memRead", {31'd0, memRead3}, 32'd0);
    chk("mid_async_ready", {31'd0, req_ready3}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset3 = 1'b0;
    rv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid3) rv_cnt++;
    end
    chk("mid_no_resp", rv_cnt, 0);
    chk("mid_ready_after", {31'd0, req_ready3}, 32'd1);
    chk("mid_rdata_cleared", resp_rdata3, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
